// File: rtl/time_base_gen.sv
// time_base_gen
//   Upstream timing stage for the stopwatch counter. It divides the system
//   clock into one-cycle strobes for seconds, minutes and hours, and it holds
//   the run/stop state machine. The state machine is driven by a debounced
//   start/stop button, and a debounced clear button realigns the time base.
//
// Ports
//   clk        in   system clock, rising-edge active
//   reset      in   asynchronous, active-low reset
//   toggle_btn in   raw start/stop button, active-high, asynchronous to clk
//   clear_btn  in   raw clear button, active-high, asynchronous to clk
//   running    out  1 while the state machine is in RUN
//   clk_sec    out  one-cycle pulse per elapsed second of RUN time
//   clk_min    out  one-cycle pulse per 60 seconds (coincident with clk_sec)
//   clk_hours  out  one-cycle pulse per 60 minutes (coincident with clk_min)
module time_base_gen #(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic toggle_btn,
  input  logic clear_btn,
  output logic running,
  output logic clk_sec,
  output logic clk_min,
  output logic clk_hours
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  // Bit 0 = toggle button, bit 1 = clear button.
  logic [1:0]    w_btn;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_db;
  logic [1:0]    r_db_d;
  logic [DW-1:0] r_db_cnt [2];
  logic [1:0]    w_rise;
  logic          w_toggle_rise;
  logic          w_clear_rise;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [5:0]    r_sec_cnt;
  logic [5:0]    r_min_cnt;
  logic          r_clk_sec;
  logic          r_clk_min;
  logic          r_clk_hours;
  logic          w_sec_evt;

  assign w_btn         = {clear_btn, toggle_btn};
  assign w_rise        = r_db & ~r_db_d;
  assign w_toggle_rise = w_rise[0];
  assign w_clear_rise  = w_rise[1];

  // Input conditioning: 2-FF synchronizer, debounce counter, rise detector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // The second-event uses the state before this edge's transition, so the
  // cycle that leaves RUN can still produce a strobe.
  assign w_sec_evt = (r_state == ST_RUN) && (r_presc == PRESC_LAST);

  // Run/stop state machine, prescaler and registered strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_STOP;
      r_presc     <= '0;
      r_sec_cnt   <= '0;
      r_min_cnt   <= '0;
      r_clk_sec   <= 1'b0;
      r_clk_min   <= 1'b0;
      r_clk_hours <= 1'b0;
    end else begin
      r_clk_sec   <= 1'b0;
      r_clk_min   <= 1'b0;
      r_clk_hours <= 1'b0;
      if (w_clear_rise) begin
        // Clear has priority over toggle and suppresses this cycle's strobe.
        r_state   <= ST_STOP;
        r_presc   <= '0;
        r_sec_cnt <= '0;
        r_min_cnt <= '0;
      end else begin
        if (w_toggle_rise) begin
          r_state <= (r_state == ST_RUN) ? ST_STOP : ST_RUN;
        end
        // In STOP the prescaler holds, so a pause keeps the partial second.
        if (r_state == ST_RUN) begin
          if (w_sec_evt) begin
            r_presc   <= '0;
            r_clk_sec <= 1'b1;
            if (r_sec_cnt == 6'd59) begin
              r_sec_cnt <= '0;
              r_clk_min <= 1'b1;
              if (r_min_cnt == 6'd59) begin
                r_min_cnt   <= '0;
                r_clk_hours <= 1'b1;
              end else begin
                r_min_cnt <= r_min_cnt + 6'd1;
              end
            end else begin
              r_sec_cnt <= r_sec_cnt + 6'd1;
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
      end
    end
  end

  assign running   = (r_state == ST_RUN);
  assign clk_sec   = r_clk_sec;
  assign clk_min   = r_clk_min;
  assign clk_hours = r_clk_hours;

endmodule

// File: tb/tb_time_base_gen.sv
`timescale 1ns/1ps
module tb_time_base_gen;

  localparam int TD = 10;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic toggle_btn = 1'b0;
  logic clear_btn = 1'b0;
  logic running;
  logic clk_sec;
  logic clk_min;
  logic clk_hours;

  time_base_gen #(
    .TICK_DIV       (TD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .toggle_btn(toggle_btn),
    .clear_btn (clear_btn),
    .running   (running),
    .clk_sec   (clk_sec),
    .clk_min   (clk_min),
    .clk_hours (clk_hours)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic s;
    logic m;
    logic h;
  } strb_t;

  strb_t exp_q[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  // Bench model: expected run state and time-base counters.
  logic m_run = 1'b0;
  int   mp = 0;
  int   ms = 0;
  int   mm = 0;
  // Window in which a run-state change is allowed (toggle latency is +-1).
  bit   win_active = 0;
  bit   win_seen = 0;
  bit   clr_pend = 0;
  int   win_start = 0;
  int   win_cyc = 0;
  // Observation counters.
  int   n_sec = 0;
  int   n_min = 0;
  int   n_hr = 0;
  int   sec_since_clr = 0;
  bit   first_pend = 0;
  int   first_sec_cyc = 0;
  bit   min_watch = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    strb_t e;
    strb_t got;
    bit    changed;
    @(posedge clk);
    #1;
    cyc++;
    changed = 0;
    if (win_active && !win_seen && (running !== m_run)) begin
      changed  = 1;
      win_seen = 1;
      win_cyc  = cyc;
    end else begin
      chk("running", 32'(running), 32'(m_run));
    end
    // Expected strobes for the edge just taken, from the pre-edge run state.
    e = '0;
    if (changed && clr_pend) begin
      mp = 0; ms = 0; mm = 0;
      sec_since_clr = 0;
    end else if (m_run) begin
      if (mp == TD - 1) begin
        mp = 0;
        e.s = 1'b1;
        if (ms == 59) begin
          ms = 0;
          e.m = 1'b1;
          if (mm == 59) begin
            mm = 0;
            e.h = 1'b1;
          end else begin
            mm++;
          end
        end else begin
          ms++;
        end
      end else begin
        mp++;
      end
    end
    exp_q.push_back(e);
    got = {clk_sec, clk_min, clk_hours};
    e = exp_q.pop_front();
    chk("clk_sec", 32'(got.s), 32'(e.s));
    chk("clk_min", 32'(got.m), 32'(e.m));
    chk("clk_hours", 32'(got.h), 32'(e.h));
    if (changed) m_run = ~m_run;
    if (clk_sec === 1'b1) begin
      n_sec++;
      sec_since_clr++;
      if (first_pend) begin
        first_pend    = 0;
        first_sec_cyc = cyc;
      end
    end
    if (clk_min === 1'b1) begin
      n_min++;
      if (min_watch) begin
        min_watch = 0;
        chk("secs_to_first_min_after_clear", 32'(sec_since_clr), 32'd60);
      end
    end
    if (clk_hours === 1'b1) n_hr++;
  endtask

  task automatic open_win(input bit is_clr);
    win_active = 1;
    win_seen   = 0;
    win_start  = cyc;
    clr_pend   = is_clr;
  endtask

  task automatic close_win(input string tag);
    int lat;
    while (cyc < win_start + 12) step();
    chk({tag, "_run_changed"}, 32'(win_seen), 32'd1);
    if (win_seen) begin
      lat = win_cyc - win_start;
      total++;
      assert (lat >= 2 + DB && lat <= 2 + DB + 2) else begin
        bad++;
        $error("FAIL %s_latency: observed=%0d expected=%0d..%0d", tag, lat, 2 + DB, 2 + DB + 2);
      end
    end
    win_active = 0;
    clr_pend   = 0;
  endtask

  task automatic press(input bit tog, input bit clr, input int n);
    if (tog) toggle_btn = 1'b1;
    if (clr) clear_btn = 1'b1;
    repeat (n) step();
    toggle_btn = 1'b0;
    clear_btn  = 1'b0;
  endtask

  task automatic wait_presc(input int v);
    for (int k = 0; k < 2 * TD && mp != v; k++) step();
    chk("reach_presc", 32'(mp), 32'(v));
  endtask

  initial begin
    int ph;
    int r0;
    // Reset state, checked before any clock edge.
    #1;
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_clk_sec", 32'(clk_sec), 32'd0);
    chk("rst_clk_min", 32'(clk_min), 32'd0);
    chk("rst_clk_hours", 32'(clk_hours), 32'd0);
    repeat (3) step();
    reset = 1'b1;

    // Idle: nothing moves.
    repeat (100) step();
    chk("idle_sec_count", 32'(n_sec), 32'd0);
    chk("idle_min_count", 32'(n_min), 32'd0);

    // Start with a long press; seconds every TD cycles.
    open_win(0);
    press(1, 0, 10);
    close_win("start");
    repeat (40) step();

    // Short glitch is ignored; a 5-cycle press stops exactly once.
    press(1, 0, 3);
    repeat (20) step();
    chk("glitch_running", 32'(running), 32'd1);
    open_win(0);
    press(1, 0, 5);
    close_win("press5");
    repeat (20) step();
    chk("press5_running", 32'(running), 32'd0);

    // Stop on the cycle where the prescaler is at its last count.
    open_win(0);
    press(1, 0, 10);
    close_win("restart1");
    wait_presc(3);
    open_win(0);
    press(1, 0, 10);
    close_win("stop_on_evt");
    repeat (10) step();

    // Pause mid-second, then resume: first second completes the remainder.
    open_win(0);
    press(1, 0, 10);
    close_win("restart2");
    wait_presc(9);
    open_win(0);
    press(1, 0, 10);
    close_win("pause");
    repeat (50) step();
    ph = mp;
    first_pend = 1;
    open_win(0);
    press(1, 0, 10);
    close_win("resume");
    for (int k = 0; k < 3 * TD && first_pend; k++) step();
    chk("first_sec_seen", 32'(first_pend), 32'd0);
    chk("first_sec_delay", 32'(first_sec_cyc - win_cyc), 32'(TD - ph));

    // Clear and toggle together while running: clear wins.
    repeat (25) step();
    open_win(1);
    press(1, 1, 10);
    close_win("clear");
    repeat (10) step();
    chk("clear_running", 32'(running), 32'd0);
    min_watch = 1;
    open_win(0);
    press(1, 0, 10);
    close_win("after_clear");
    for (int k = 0; k < 700 && min_watch; k++) step();
    chk("min_after_clear_seen", 32'(min_watch), 32'd0);

    // Asynchronous reset while a second strobe is high.
    for (int k = 0; k < 2 * TD && clk_sec !== 1'b1; k++) step();
    chk("sec_high_before_reset", 32'(clk_sec), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_running", 32'(running), 32'd0);
    chk("async_rst_clk_sec", 32'(clk_sec), 32'd0);
    chk("async_rst_clk_min", 32'(clk_min), 32'd0);
    chk("async_rst_clk_hours", 32'(clk_hours), 32'd0);
    m_run = 1'b0;
    mp = 0; ms = 0; mm = 0;
    exp_q.delete();
    repeat (3) step();
    reset = 1'b1;
    repeat (5) step();

    // Long run from a fresh reset: minute and hour strobes.
    open_win(0);
    press(1, 0, 10);
    close_win("long_run");
    r0 = win_cyc;
    n_sec = 0; n_min = 0; n_hr = 0;
    while (cyc < r0 + 60 * TD) step();
    chk("sec_count_1min", 32'(n_sec), 32'd60);
    chk("min_count_1min", 32'(n_min), 32'd1);
    chk("hr_count_1min", 32'(n_hr), 32'd0);
    while (cyc < r0 + 3600 * TD + 5) step();
    chk("sec_count_1hr", 32'(n_sec), 32'd3600);
    chk("min_count_1hr", 32'(n_min), 32'd60);
    chk("hr_count_1hr", 32'(n_hr), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_base_gen.md
Name: time_base_gen

Overview:
Upstream timing stage for the stopwatch counter. Divides the system clock into the one-second, one-minute and one-hour strobes that drive the counter's clk_sec / clk_min / clk_hours inputs. Owns the run/stop state machine, driven by a debounced toggle button, and a clear button that realigns the time base. Every strobe is a one-cycle high pulse, so each produces exactly one falling edge per elapsed unit.

Parameters:
TICK_DIV, 50000000, system clock cycles per second; legal range >= 2.
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized cycles required before a button level is accepted; legal range >= 1.

Ports:
clk  input  1  system clock; all state is updated on its rising edge.
reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
toggle_btn  input  1  raw start/stop push-button, active-high, asynchronous to clk.
clear_btn  input  1  raw clear push-button, active-high, asynchronous to clk.
running  output  1  1 when the FSM is in RUN.
clk_sec  output  1  one-cycle pulse per elapsed second.
clk_min  output  1  one-cycle pulse per 60 seconds.
clk_hours  output  1  one-cycle pulse per 60 minutes.

Behaviour:
- Reset (reset=0): FSM=STOP; presc, sec_cnt, min_cnt = 0; synchronizers, debounced levels and debounce counters = 0; running, clk_sec, clk_min, clk_hours = 0.
- Input conditioning, per button:
  - 2-FF synchronizer.
  - Debounce counter: clears whenever the synchronized level equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized level and the counter clears.
  - An edge detector produces a one-cycle rise strobe on each debounced 0->1 transition.
  - Pulses shorter than DEBOUNCE_CYCLES are ignored.
- FSM states are STOP and RUN. running is the registered state.
  - STOP -> RUN on toggle_rise.
  - RUN -> STOP on toggle_rise.
  - Any state -> STOP on clear_rise.
  - clear_rise wins over a simultaneous toggle_rise.
- Clear action (on clear_rise): presc, sec_cnt and min_cnt = 0. No strobe is emitted that cycle. A strobe already asserted still completes its single cycle.
- Prescaler:
  - Widths: presc is clog2(TICK_DIV) bits; sec_cnt and min_cnt are 6 bits each.
  - In RUN, presc increments each cycle.
  - When presc == TICK_DIV-1 in RUN, presc wraps to 0 and a second-event fires.
  - In STOP, presc holds its value, so a pause preserves the partial second.
- Second-event:
  - clk_sec is 1 on the next cycle (registered, latency 1), else 0.
  - sec_cnt increments.
  - If sec_cnt == 59: sec_cnt wraps to 0, clk_min pulses in the same cycle as clk_sec, and min_cnt increments.
  - If also min_cnt == 59: min_cnt wraps to 0 and clk_hours pulses in the same cycle.
- Strobe spacing: strobes are never high for two consecutive cycles, since TICK_DIV >= 2.
  - clk_sec pulses exactly every TICK_DIV cycles of RUN time.
  - clk_min pulses every 60*TICK_DIV cycles.
  - clk_hours pulses every 3600*TICK_DIV cycles.
- Entering RUN: the first clk_sec follows TICK_DIV - presc_held cycles of RUN time.
- Toggle latency: from a clean toggle_btn rise, running changes after 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, ±1.
- Event on the stop cycle: if the cycle that leaves RUN also has presc == TICK_DIV-1, the second-event still fires, because evaluation uses the pre-transition state.
- Reset mid-pulse: all outputs drop to 0 asynchronously. This produces a falling edge downstream; that edge is accepted behaviour.

Test Plan (TICK_DIV=10, DEBOUNCE_CYCLES=4):
1. Release reset; hold all buttons 0 for 100 cycles -> running=0, no strobe ever asserts.
2. toggle_btn high for 10 cycles -> running=1 within 2+4+1(±1) cycles; clk_sec then pulses every 10 cycles, each pulse exactly 1 cycle wide.
3. toggle_btn glitches of 3 cycles (high) -> running unchanged; a 5-cycle press -> running toggles exactly once.
4. Run for 600 cycles -> 60 clk_sec pulses, 1 clk_min pulse coincident with the 60th clk_sec; run for 36000 cycles -> clk_hours pulses once, coincident with the 60th clk_min.
5. Run, stop at presc=6, wait 50 cycles, restart -> first clk_sec arrives 4 cycles after running returns to 1.
6. In RUN, press clear_btn and toggle_btn on the same cycle -> running=0, internal counters 0; after restart the first clk_min arrives after 60 full seconds. Separately, assert reset mid-run -> all outputs 0 immediately.
